// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase controller.
// Holds the phase enum, lamp codes {R,Y,G} and default phase durations.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED1  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED2  = 3'd5,
        WALK      = 3'd6
    } phase_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam int DEF_GREEN_CYC  = 20;
    localparam int DEF_YELLOW_CYC = 4;
    localparam int DEF_ALLRED_CYC = 2;
    localparam int DEF_WALK_CYC   = 10;
    localparam int DEF_TIMER_W    = 8;

    // North-south lamp code shown while in a given phase.
    function automatic logic [2:0] ns_lamp(input phase_e s);
        case (s)
            NS_GREEN:  return LAMP_GRN;
            NS_YELLOW: return LAMP_YEL;
            default:   return LAMP_RED;
        endcase
    endfunction

    // East-west lamp code shown while in a given phase.
    function automatic logic [2:0] ew_lamp(input phase_e s);
        case (s)
            EW_GREEN:  return LAMP_GRN;
            EW_YELLOW: return LAMP_YEL;
            default:   return LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase tick counter. Counts ticks from zero after each restart and
// flags done on the tick that completes the programmed duration.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Clear,
    input  logic         tick,
    input  logic         restart,
    input  logic [W-1:0] dur,
    output logic         done
);

    logic [W-1:0] cnt_q;

    // Final tick of the phase: the edge on which the owner changes phase.
    assign done = tick && (cnt_q == dur - W'(1));

    // Count ticks; zero on reset or when a new phase begins.
    always_ff @(posedge Clk) begin
        if (Clear || restart) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic phase controller with optional pedestrian walk phase.
// Build option: define TRAFFIC_PED_WALK_EN to compile in the WALK phase,
// the pending-request latch and the ped_ack/walk outputs. Without it the
// cycle skips WALK, ped_req is ignored and ped_ack/walk stay low.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_CYC  = DEF_GREEN_CYC,
    parameter int YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int ALLRED_CYC = DEF_ALLRED_CYC,
    parameter int WALK_CYC   = DEF_WALK_CYC,
    parameter int TIMER_W    = DEF_TIMER_W
) (
    input  logic       Clk,
    input  logic       Clear,
    input  logic       tick,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       load,
    output logic       En
);

    phase_e             state_q;
    phase_e             state_d;
    logic [TIMER_W-1:0] dur;
    logic               phase_done;
    logic [2:0]         ns_q;
    logic [2:0]         ew_q;
    logic               load_q;
    logic               en_q;

`ifdef TRAFFIC_PED_WALK_EN
    logic pending_q;
    logic walk_q;
    logic ped_ack_q;
    logic ped_accept;
    logic entering_walk;

    // A new request is taken only when none is queued and we are not walking.
    assign ped_accept    = ped_req && !pending_q && (state_q != WALK);
    assign entering_walk = phase_done && (state_d == WALK);
    assign walk          = walk_q;
    assign ped_ack       = ped_ack_q;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign walk           = 1'b0;
    assign ped_ack        = 1'b0;
`endif

    // Duration of the phase currently being timed.
    always_comb begin
        dur = TIMER_W'(ALLRED_CYC);
        case (state_q)
            NS_GREEN, EW_GREEN:   dur = TIMER_W'(GREEN_CYC);
            NS_YELLOW, EW_YELLOW: dur = TIMER_W'(YELLOW_CYC);
            WALK:                 dur = TIMER_W'(WALK_CYC);
            default:              dur = TIMER_W'(ALLRED_CYC);
        endcase
    end

    phase_timer #(
        .W(TIMER_W)
    ) u_timer (
        .Clk    (Clk),
        .Clear  (Clear),
        .tick   (tick),
        .restart(phase_done),
        .dur    (dur),
        .done   (phase_done)
    );

    // Successor phase; the walk decision uses the already-latched request so
    // a request arriving on the ALL_RED2 exit edge waits a full cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            NS_GREEN:  state_d = NS_YELLOW;
            NS_YELLOW: state_d = ALL_RED1;
            ALL_RED1:  state_d = EW_GREEN;
            EW_GREEN:  state_d = EW_YELLOW;
            EW_YELLOW: state_d = ALL_RED2;
`ifdef TRAFFIC_PED_WALK_EN
            ALL_RED2:  state_d = pending_q ? WALK : NS_GREEN;
`else
            ALL_RED2:  state_d = NS_GREEN;
`endif
            WALK:      state_d = NS_GREEN;
            default:   state_d = ALL_RED2;
        endcase
    end

    // Phase FSM with registered lamp, strobe, enable and pedestrian outputs.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            state_q   <= ALL_RED2;
            ns_q      <= LAMP_RED;
            ew_q      <= LAMP_RED;
            load_q    <= 1'b0;
            en_q      <= 1'b0;
`ifdef TRAFFIC_PED_WALK_EN
            pending_q <= 1'b0;
            walk_q    <= 1'b0;
            ped_ack_q <= 1'b0;
`endif
        end else begin
            en_q   <= 1'b1;
            load_q <= phase_done;
            if (phase_done) begin
                state_q <= state_d;
                ns_q    <= ns_lamp(state_d);
                ew_q    <= ew_lamp(state_d);
            end
`ifdef TRAFFIC_PED_WALK_EN
            ped_ack_q <= ped_accept;
            if (entering_walk) begin
                pending_q <= 1'b0;
            end else if (ped_accept) begin
                pending_q <= 1'b1;
            end
            if (phase_done) begin
                walk_q <= (state_d == WALK);
            end
`endif
        end
    end

    assign ns_light = ns_q;
    assign ew_light = ew_q;
    assign load     = load_q;
    assign En       = en_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with a cycle scoreboard. A
// countdown reference model pushes the expected outputs of each edge as the
// stimulus is applied; they are popped and compared just after the edge.
`timescale 1ns/1ps
module tb_traffic_phase_ctrl;

    localparam int G  = 3;
    localparam int Y  = 2;
    localparam int AR = 1;
    localparam int WK = 2;
    localparam int TW = 8;
`ifdef TRAFFIC_PED_WALK_EN
    localparam bit WALK_EN = 1'b1;
`else
    localparam bit WALK_EN = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Clear;
    logic       tick;
    logic       ped_req;
    logic       ped_ack;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       load;
    logic       En;

    traffic_phase_ctrl #(
        .GREEN_CYC (G),
        .YELLOW_CYC(Y),
        .ALLRED_CYC(AR),
        .WALK_CYC  (WK),
        .TIMER_W   (TW)
    ) dut (
        .Clk     (Clk),
        .Clear   (Clear),
        .tick    (tick),
        .ped_req (ped_req),
        .ped_ack (ped_ack),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .walk    (walk),
        .load    (load),
        .En      (En)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
        logic       load;
        logic       ack;
        logic       en;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_no  = 0;
    int   ack_cnt = 0;
    int   walk_cnt = 0;

    // Reference model: phase index 0..6 = NSG,NSY,AR1,EWG,EWY,AR2,WALK,
    // with the number of ticks still to run in the current phase.
    int   m_phase = 5;
    int   m_left  = AR;
    bit   m_pend  = 1'b0;
    int         dur_tab [7] = '{G, Y, AR, G, Y, AR, WK};
    logic [2:0] ns_tab  [7] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_tab  [7] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};

    task automatic model_step(input logic t, input logic r, input logic c);
        exp_t e;
        int   nxt;
        e = '0;
        if (c) begin
            m_phase = 5;
            m_left  = AR;
            m_pend  = 1'b0;
        end else begin
            e.en  = 1'b1;
            e.ack = WALK_EN && r && !m_pend && (m_phase != 6);
            if (t) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_phase == 5)      nxt = (WALK_EN && m_pend) ? 6 : 0;
                    else if (m_phase == 6) nxt = 0;
                    else                   nxt = m_phase + 1;
                    if (nxt == 6) m_pend = 1'b0;
                    m_phase = nxt;
                    m_left  = dur_tab[nxt];
                    e.load  = 1'b1;
                end
            end
            if (e.ack) m_pend = 1'b1;
        end
        e.ns   = ns_tab[m_phase];
        e.ew   = ew_tab[m_phase];
        e.walk = (m_phase == 6);
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s cycle %0d observed %b expected %b", tag, cyc_no, obs, exp_v);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s cycle %0d observed %0d expected %0d", tag, cyc_no, obs, exp_v);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        n_tests++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL sb_empty cycle %0d observed 0 entries expected 1", cyc_no);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ns_light", ns_light, e.ns);
            chk("ew_light", ew_light, e.ew);
            chk("walk", {2'b00, walk}, {2'b00, e.walk});
            chk("load", {2'b00, load}, {2'b00, e.load});
            chk("ped_ack", {2'b00, ped_ack}, {2'b00, e.ack});
            chk("en", {2'b00, En}, {2'b00, e.en});
            chk("conflict", {2'b00, (ns_light !== 3'b100) && (ew_light !== 3'b100)}, 3'b000);
        end
    endtask

    // One clock: drive inputs, predict, clock, compare.
    task automatic cyc(input logic t, input logic r, input logic c);
        tick    = t;
        ped_req = r;
        Clear   = c;
        model_step(t, r, c);
        @(posedge Clk);
        #1;
        cyc_no++;
        ack_cnt  += int'(ped_ack === 1'b1);
        walk_cnt += int'(walk === 1'b1);
        $display("[TB] cyc %0d tick=%b req=%b clr=%b ns=%b ew=%b walk=%b load=%b ack=%b en=%b",
                 cyc_no, t, r, c, ns_light, ew_light, walk, load, ped_ack, En);
        check_outputs();
    endtask

    // Free-run until the model reaches phase p (bounded).
    task automatic adv_to(input int p);
        for (int i = 0; i < 30 && m_phase != p; i++) cyc(1'b1, 1'b0, 1'b0);
        if (m_phase != p) begin
            n_tests++;
            n_fail++;
            $display("FAIL adv_to cycle %0d observed phase %0d expected %0d", cyc_no, m_phase, p);
        end
    endtask

    initial begin
        Clear   = 1'b1;
        tick    = 1'b1;
        ped_req = 1'b0;

        // Reset with tick high, then release: first edge goes to NS_GREEN.
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("release_ns", ns_light, 3'b001);
        chk("release_load", {2'b00, load}, 3'b001);

        // Two full periods of free running.
        repeat (24) cyc(1'b1, 1'b0, 1'b0);

        // Single request pulse in NS_GREEN.
        adv_to(0);
        ack_cnt = 0; walk_cnt = 0;
        cyc(1'b1, 1'b1, 1'b0);
        repeat (20) cyc(1'b1, 1'b0, 1'b0);
        chk_int("pulse_ack_count", ack_cnt, WALK_EN ? 1 : 0);
        chk_int("pulse_walk_count", walk_cnt, WALK_EN ? WK : 0);

        // Request held for five cycles.
        adv_to(0);
        ack_cnt = 0; walk_cnt = 0;
        repeat (5) cyc(1'b1, 1'b1, 1'b0);
        repeat (20) cyc(1'b1, 1'b0, 1'b0);
        chk_int("held_ack_count", ack_cnt, WALK_EN ? 1 : 0);
        chk_int("held_walk_count", walk_cnt, WALK_EN ? WK : 0);

        // Tick every fourth clock, then a long tick-free freeze.
        for (int i = 0; i < 60; i++) cyc((i % 4) == 3, 1'b0, 1'b0);
        repeat (50) cyc(1'b0, 1'b0, 1'b0);
        repeat (8) cyc(1'b1, 1'b0, 1'b0);

        // Clear during EW_GREEN with a request pending: no WALK afterwards.
        adv_to(3);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("clear_ns", ns_light, 3'b100);
        chk("clear_ew", ew_light, 3'b100);
        ack_cnt = 0; walk_cnt = 0;
        repeat (20) cyc(1'b1, 1'b0, 1'b0);
        chk_int("clear_walk_count", walk_cnt, 0);

        // Request on the ALL_RED2 exit edge: walk deferred one full cycle.
        adv_to(5);
        ack_cnt = 0; walk_cnt = 0;
        cyc(1'b1, 1'b1, 1'b0);
        chk("defer_ns", ns_light, 3'b001);
        chk("defer_walk", {2'b00, walk}, 3'b000);
        repeat (16) cyc(1'b1, 1'b0, 1'b0);
        chk_int("defer_ack_count", ack_cnt, WALK_EN ? 1 : 0);
        chk_int("defer_walk_count", walk_cnt, WALK_EN ? WK : 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameter GREEN_CYC, default 20: green duration, in tick pulses (>=1).
REQ-002 Parameter YELLOW_CYC, default 4: yellow duration, in ticks (>=1).
REQ-003 Parameter ALLRED_CYC, default 2: all-red clearance duration, in ticks (>=1).
REQ-004 Parameter WALK_CYC, default 10: pedestrian walk duration, in ticks (>=1).
REQ-005 Parameter TIMER_W, default 8: phase timer width; every duration SHALL fit in TIMER_W bits.
REQ-006 Port Clk, input, 1: the single clock; all state changes on the rising edge.
REQ-007 Port Clear, input, 1: reset, synchronous and active-high.
REQ-008 Port tick, input, 1: one-cycle timebase enable; only ticked cycles advance timers.
REQ-009 Port ped_req, input, 1: pedestrian request, level or pulse.
REQ-010 Port ped_ack, output, 1: one-cycle acknowledge of an accepted request.
REQ-011 Port ns_light, output, 3: north-south lamp code {R,Y,G}, one-hot.
REQ-012 Port ew_light, output, 3: east-west lamp code {R,Y,G}, one-hot.
REQ-013 Port walk, output, 1: walk lamp.
REQ-014 Port load, output, 1: one-cycle strobe to the downstream lamp register bank.
REQ-015 Port En, output, 1: enable to the downstream lamp register bank; 0 during reset, 1 otherwise.

Function
REQ-016 FSM states: NS_GREEN, NS_YELLOW, ALL_RED1, EW_GREEN, EW_YELLOW, ALL_RED2, WALK.
REQ-017 Sequence: ALL_RED2 -> (WALK if pending) -> NS_GREEN -> NS_YELLOW -> ALL_RED1 -> EW_GREEN -> EW_YELLOW -> ALL_RED2.
REQ-018 Timer: clears on each state entry and increments only on tick.
REQ-019 A state SHALL exit on the edge where tick=1 and timer==duration-1, so a state lasts exactly its duration in ticks.
REQ-020 With tick=0 the FSM, timer and all outputs SHALL hold indefinitely.
REQ-021 Lamp codes are registered and change on the same edge as the state: red=100, yellow=010, green=001.
REQ-022 Per state: NS_GREEN ns=001/ew=100; NS_YELLOW ns=010/ew=100; EW_GREEN ns=100/ew=001; EW_YELLOW ns=100/ew=010; ALL_RED1, ALL_RED2 and WALK: both 100.
REQ-023 The two roads SHALL never be non-red at the same time.
REQ-024 walk=1 only in WALK.
REQ-025 load=1 for exactly the one cycle in which new lamp codes are first presented (the cycle after a transition edge); load=0 otherwise.
REQ-026 Request acceptance: ped_req=1 while not pending and state!=WALK sets pending and pulses ped_ack on the next cycle.
REQ-027 A held or repeated ped_req while pending, or any ped_req during WALK, SHALL be ignored (no ack).
REQ-028 pending clears on the edge that enters WALK.
REQ-029 If ped_req arrives on the same edge that ALL_RED2 exits, WALK SHALL be deferred to the next ALL_RED2.

Reset
REQ-030 Clear=1 at an edge forces, regardless of tick or state: state=ALL_RED2, timer=0, ns_light=ew_light=100, walk=0, load=0, ped_ack=0, pending=0, En=0.
REQ-031 On the first edge with Clear=0, En SHALL go to 1.
REQ-032 A Clear asserted mid-phase SHALL discard the pending request and the remaining phase time.

Configuration
REQ-033 Macro TRAFFIC_PED_WALK_EN defined: the WALK state, pending latch and ped_ack/walk logic are compiled in as specified above.
REQ-034 Macro undefined: WALK is absent, ALL_RED2 always goes to NS_GREEN, ped_req is ignored, and ped_ack=0 and walk=0 constantly.

Structure
REQ-035 Shared package traffic_pkg holds the state enum, lamp code constants (LAMP_RED, LAMP_YEL, LAMP_GRN) and the default durations.
REQ-036 Sub-module phase_timer (inputs Clk, Clear, tick, restart, dur; output done) implements the per-phase counter.
REQ-037 The FSM, pending latch and output registers remain in traffic_phase_ctrl.

Verification
REQ-038 Bench parameters: GREEN=3, YELLOW=2, ALLRED=1, WALK=2.
REQ-039 Reset: Clear=1 for 2 cycles with tick=1 -> ns=ew=100, En=0, load=0; first ticked edge after release -> ns=001, load=1 for one cycle, En=1.
REQ-040 Free run, tick=1 every cycle -> ns 001x3, 010x2, 100x1, then ew 001x3, 010x2, 100x1; period 12 cycles; ns and ew never both non-red.
REQ-041 ped_req pulse in NS_GREEN -> ped_ack one cycle later; after ALL_RED2, walk=1 for 2 ticks with both lamps 100, then ns=001.
REQ-042 ped_req held high 5 cycles -> exactly one ped_ack pulse and one WALK.
REQ-043 tick every 4th cycle -> NS_GREEN lasts 12 clocks; tick=0 for 50 cycles -> all outputs frozen, load=0.
REQ-044 Clear pulsed during EW_GREEN with a request pending -> both lamps 100 next cycle; after release the sequence is NS_GREEN with no WALK (macro defined).
